dmem_access: RTL and testbench

MEM-stage data-memory access unit: consumes the EX/MEM pipeline register outputs and drives the core's SRAM-like data bus (req/addr_ok/data_ok, one outstanding transaction). It selects access size and lane, replicates store data across lanes, extracts and sign-/zero-extends load data, and asserts a stall request toward the pipeline controller until the access completes. It also buffers returned load data while the next stage is stalled, so an access is never re-issued.

---
 rtl/dmem_access.sv | 167 ++++++++++++++++
 tb/tb_dmem_access.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access.sv
// MEM-stage data-memory access unit; optional DMEM_UNALIGNED_EXC_EN adds misaligned-address faults.
// Latency: request and addr_ok in cycle N, data_ok and load_data_o in N+1 at the earliest.
// Backpressure: stall_request_o holds the pipeline until the bus finishes; a stalled MEM/WB parks the load data in a buffer.
module dmem_access (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        stall_next_stage,
   input  logic        mem_read_flag_i,
   input  logic        mem_write_flag_i,
   input  logic        mem_sign_ext_flag_i,
   input  logic [3:0]  mem_sel_i,
   input  logic [31:0] mem_write_data_i,
   input  logic [31:0] result_i,
   input  logic [31:0] exception_type_i,
   output logic        data_req,
   output logic        data_wr,
   output logic [1:0]  data_size,
   output logic [31:0] data_addr,
   output logic [31:0] data_wdata,
   input  logic        data_addr_ok,
   input  logic        data_data_ok,
   input  logic [31:0] data_rdata,
   output logic [31:0] load_data_o,
   output logic        stall_request_o,
   output logic        adel_o,
   output logic        ades_o,
   output logic [31:0] bad_vaddr_o
);

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_DRAIN} state_t;

   state_t      state, state_nxt;
   logic [1:0]  acc_size;
   logic [1:0]  lane;
   logic [31:0] wdata_rep;
   logic [31:0] shifted;
   logic [31:0] load_ext;
   logic [31:0] load_buf;
   logic        buf_load;
   logic        base_valid;
   logic        access_valid;
   logic        req_int;

   always_comb begin
      acc_size = 2'd2;
      lane     = 2'd0;
      case (mem_sel_i)
         4'b0001: begin acc_size = 2'd0; lane = 2'd0; end
         4'b0010: begin acc_size = 2'd0; lane = 2'd1; end
         4'b0100: begin acc_size = 2'd0; lane = 2'd2; end
         4'b1000: begin acc_size = 2'd0; lane = 2'd3; end
         4'b0011: begin acc_size = 2'd1; lane = 2'd0; end
         4'b1100: begin acc_size = 2'd1; lane = 2'd2; end
         default: begin acc_size = 2'd2; lane = 2'd0; end
      endcase
   end

   always_comb begin
      case (acc_size)
         2'd0:    wdata_rep = {4{mem_write_data_i[7:0]}};
         2'd1:    wdata_rep = {2{mem_write_data_i[15:0]}};
         default: wdata_rep = mem_write_data_i;
      endcase
   end

   assign shifted = data_rdata >> {lane, 3'b000};

   always_comb begin
      case (acc_size)
         2'd0:    load_ext = {{24{mem_sign_ext_flag_i & shifted[7]}}, shifted[7:0]};
         2'd1:    load_ext = {{16{mem_sign_ext_flag_i & shifted[15]}}, shifted[15:0]};
         default: load_ext = shifted;
      endcase
   end

   // rst gates the request so every output reads 0 while reset is held
   assign base_valid = ~rst & (mem_read_flag_i | mem_write_flag_i)
                     & (exception_type_i == 32'd0) & ~flush;

`ifdef DMEM_UNALIGNED_EXC_EN
   logic misaligned;
   logic addr_fault;

   assign misaligned   = ((acc_size == 2'd2) & (result_i[1:0] != 2'b00))
                       | ((acc_size == 2'd1) & result_i[0]);
   assign addr_fault   = base_valid & misaligned & (state == S_IDLE);
   assign access_valid = base_valid & ~misaligned;
   assign adel_o       = addr_fault & mem_read_flag_i;
   assign ades_o       = addr_fault & mem_write_flag_i;
   assign bad_vaddr_o  = addr_fault ? result_i : 32'd0;
`else
   logic unused_addr_bits;

   assign unused_addr_bits = ^result_i[1:0];
   assign access_valid     = base_valid;
   assign adel_o           = 1'b0;
   assign ades_o           = 1'b0;
   assign bad_vaddr_o      = 32'd0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         load_buf <= 32'd0;
      end else begin
         state <= state_nxt;
         if (buf_load) load_buf <= load_ext;
      end
   end

   always_comb begin
      state_nxt       = state;
      req_int         = 1'b0;
      stall_request_o = 1'b0;
      load_data_o     = 32'd0;
      buf_load        = 1'b0;
      case (state)
         S_IDLE: begin
            if (access_valid) begin
               req_int         = 1'b1;
               stall_request_o = 1'b1;
               state_nxt       = data_addr_ok ? S_WAIT : S_REQ;
            end
         end
         S_REQ: begin
            req_int         = 1'b1;
            stall_request_o = 1'b1;
            // an accepted address must still see its data_ok, even when flushed
            if (data_addr_ok)  state_nxt = flush ? S_DRAIN : S_WAIT;
            else if (flush)    state_nxt = S_IDLE;
         end
         S_WAIT: begin
            if (data_data_ok) begin
               load_data_o = load_ext;
               if (flush) begin
                  state_nxt = S_IDLE;
               end else if (stall_next_stage) begin
                  buf_load  = 1'b1;
                  state_nxt = S_DONE;
               end else begin
                  state_nxt = S_IDLE;
               end
            end else begin
               stall_request_o = 1'b1;
               if (flush) state_nxt = S_DRAIN;
            end
         end
         S_DONE: begin
            load_data_o = load_buf;
            if (~stall_next_stage | flush) state_nxt = S_IDLE;
         end
         S_DRAIN: begin
            stall_request_o = 1'b1;
            if (data_data_ok) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign data_req   = req_int;
   assign data_wr    = req_int & mem_write_flag_i;
   assign data_size  = req_int ? acc_size : 2'd0;
   assign data_addr  = req_int ? {result_i[31:2], lane} : 32'd0;
   assign data_wdata = req_int ? wdata_rep : 32'd0;

endmodule

// File: tb/tb_dmem_access.sv
// Bench for dmem_access: hand vector table, directed flush/reset/alignment sequences, random transactions vs a reference model.
module tb_dmem_access;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush, stall_next_stage;
   logic        mem_read_flag_i, mem_write_flag_i, mem_sign_ext_flag_i;
   logic [3:0]  mem_sel_i;
   logic [31:0] mem_write_data_i, result_i, exception_type_i;
   logic        data_req, data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr, data_wdata;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;
   logic [31:0] load_data_o;
   logic        stall_request_o, adel_o, ades_o;
   logic [31:0] bad_vaddr_o;

   int vec_cnt = 0;
   int mis_cnt = 0;
   int cur_txn = 0;

   always #5 clk = ~clk;

   dmem_access dut (
      .clk(clk), .rst(rst), .flush(flush), .stall_next_stage(stall_next_stage),
      .mem_read_flag_i(mem_read_flag_i), .mem_write_flag_i(mem_write_flag_i),
      .mem_sign_ext_flag_i(mem_sign_ext_flag_i), .mem_sel_i(mem_sel_i),
      .mem_write_data_i(mem_write_data_i), .result_i(result_i),
      .exception_type_i(exception_type_i),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .load_data_o(load_data_o), .stall_request_o(stall_request_o),
      .adel_o(adel_o), .ades_o(ades_o), .bad_vaddr_o(bad_vaddr_o)
   );

   typedef struct {
      logic        rd, wr, sext;
      logic [3:0]  sel;
      logic [31:0] wd, addr, rdata;
      int          aok, dok, hold;
      logic [1:0]  e_size;
      logic [31:0] e_addr, e_wdata, e_load;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         mis_cnt++;
         $display("FAIL %s (txn %0d): actual=%h required=%h", name, cur_txn, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic clear_inputs();
      flush = 0; stall_next_stage = 0;
      mem_read_flag_i = 0; mem_write_flag_i = 0; mem_sign_ext_flag_i = 0;
      mem_sel_i = 4'b0000; mem_write_data_i = 0; result_i = 0; exception_type_i = 0;
      data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
   endtask

   task automatic set_access(input logic rd, input logic wr, input logic sext, input logic [3:0] sel,
                             input logic [31:0] wd, input logic [31:0] addr);
      mem_read_flag_i = rd; mem_write_flag_i = wr; mem_sign_ext_flag_i = sext;
      mem_sel_i = sel; mem_write_data_i = wd; result_i = addr;
      exception_type_i = 0; flush = 0;
   endtask

   // Reference model: sizes and lanes from the byte-enable pattern, arithmetic on bytes
   function automatic int ref_nbytes(input logic [3:0] sel);
      int n = 0;
      for (int b = 0; b < 4; b++) if (sel[b]) n++;
      return n;
   endfunction

   function automatic int ref_lane(input logic [3:0] sel);
      for (int b = 0; b < 4; b++) if (sel[b]) return b;
      return 0;
   endfunction

   function automatic logic [1:0] ref_size(input logic [3:0] sel);
      int n = ref_nbytes(sel);
      return (n == 4) ? 2'd2 : (n == 2) ? 2'd1 : 2'd0;
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [3:0] sel, input logic [31:0] wd);
      logic [31:0] r = 0;
      int nb = ref_nbytes(sel);
      for (int b = 0; b < 4; b++) r[8*b +: 8] = wd[8*(b % nb) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] ref_load(input logic [3:0] sel, input logic sext, input logic [31:0] rdata);
      int nb = ref_nbytes(sel);
      logic [31:0] v = rdata >> (8 * ref_lane(sel));
      logic [31:0] mask;
      logic neg;
      if (nb == 4) return v;
      mask = (32'h1 << (8 * nb)) - 32'h1;
      neg  = sext && v[8*nb-1];
      v    = v & mask;
      if (neg) v = v | ~mask;
      return v;
   endfunction

   task automatic do_txn(input vec_t v);
      for (int i = 0; i <= v.aok; i++) begin
         next_cycle();
         if (i == 0) set_access(v.rd, v.wr, v.sext, v.sel, v.wd, v.addr);
         data_addr_ok = (i == v.aok); data_data_ok = 0; stall_next_stage = 0;
         settle();
         chk("addr_phase_req", data_req, 1);
         chk("addr_phase_wr", data_wr, v.wr);
         chk("addr_phase_size", data_size, v.e_size);
         chk("addr_phase_addr", data_addr, v.e_addr);
         if (v.wr) chk("addr_phase_wdata", data_wdata, v.e_wdata);
         chk("addr_phase_stall", stall_request_o, 1);
      end
      for (int i = 1; i < v.dok; i++) begin
         next_cycle();
         data_addr_ok = 0;
         settle();
         chk("wait_req", data_req, 0);
         chk("wait_stall", stall_request_o, 1);
      end
      next_cycle();
      data_addr_ok = 0; data_data_ok = 1; data_rdata = v.rdata;
      stall_next_stage = (v.hold > 0);
      settle();
      chk("dataok_stall", stall_request_o, 0);
      chk("dataok_req", data_req, 0);
      if (v.rd) chk("dataok_load", load_data_o, v.e_load);
      for (int k = 0; k < v.hold; k++) begin
         next_cycle();
         data_data_ok = 0; data_rdata = $urandom;
         stall_next_stage = (k < v.hold - 1);
         settle();
         if (v.rd) chk("done_load", load_data_o, v.e_load);
         chk("done_stall", stall_request_o, 0);
         chk("done_req", data_req, 0);
      end
      next_cycle();
      clear_inputs();
      settle();
      chk("idle_req", data_req, 0);
      chk("idle_stall", stall_request_o, 0);
      chk("idle_load", load_data_o, 0);
      chk("idle_adel", adel_o, 0);
      chk("idle_bad_vaddr", bad_vaddr_o, 0);
   endtask

   vec_t tbl[11];
   logic [3:0] sels[7];

   initial begin
      //          rd wr sx sel      wd            addr          rdata        aok dok hold size  e_addr        e_wdata       e_load
      tbl[0]  = '{1, 0, 1, 4'b1111, 32'h0,        32'h0000_1000, 32'hDEADBEEF, 0, 1, 0, 2'd2, 32'h0000_1000, 32'h0,        32'hDEADBEEF};
      tbl[1]  = '{1, 0, 1, 4'b0010, 32'h0,        32'h0000_2001, 32'h0000_8000, 0, 1, 0, 2'd0, 32'h0000_2001, 32'h0,        32'hFFFF_FF80};
      tbl[2]  = '{1, 0, 0, 4'b0010, 32'h0,        32'h0000_2001, 32'h0000_8000, 0, 1, 0, 2'd0, 32'h0000_2001, 32'h0,        32'h0000_0080};
      tbl[3]  = '{1, 0, 1, 4'b1100, 32'h0,        32'h0000_3002, 32'h8001_0000, 0, 1, 0, 2'd1, 32'h0000_3002, 32'h0,        32'hFFFF_8001};
      tbl[4]  = '{1, 0, 0, 4'b0011, 32'h0,        32'h0000_3000, 32'h1234_F00D, 1, 1, 0, 2'd1, 32'h0000_3000, 32'h0,        32'h0000_F00D};
      tbl[5]  = '{1, 0, 1, 4'b1000, 32'h0,        32'h0000_4003, 32'h7F00_0000, 0, 2, 0, 2'd0, 32'h0000_4003, 32'h0,        32'h0000_007F};
      tbl[6]  = '{0, 1, 0, 4'b0100, 32'h0000_00A5, 32'h0000_5002, 32'h0,       0, 1, 0, 2'd0, 32'h0000_5002, 32'hA5A5_A5A5, 32'h0};
      tbl[7]  = '{0, 1, 0, 4'b1100, 32'h1234_ABCD, 32'h0000_6002, 32'h0,       3, 1, 0, 2'd1, 32'h0000_6002, 32'hABCD_ABCD, 32'h0};
      tbl[8]  = '{0, 1, 0, 4'b1111, 32'hCAFE_F00D, 32'h0000_7000, 32'h0,       1, 2, 0, 2'd2, 32'h0000_7000, 32'hCAFE_F00D, 32'h0};
      tbl[9]  = '{1, 0, 0, 4'b1111, 32'h0,        32'h0000_8000, 32'h89AB_CDEF, 0, 1, 2, 2'd2, 32'h0000_8000, 32'h0,        32'h89AB_CDEF};
      tbl[10] = '{1, 0, 1, 4'b0001, 32'h0,        32'h0000_9000, 32'h0000_00FF, 0, 3, 1, 2'd0, 32'h0000_9000, 32'h0,        32'hFFFF_FFFF};
      sels = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

      rst = 1;
      clear_inputs();
      #12;
      chk("reset_req", data_req, 0);
      chk("reset_stall", stall_request_o, 0);
      chk("reset_load", load_data_o, 0);
      chk("reset_addr", data_addr, 0);
      chk("reset_size", data_size, 0);
      chk("reset_adel", adel_o, 0);
      next_cycle();
      rst = 0;

      foreach (tbl[i]) begin
         cur_txn = i;
         do_txn(tbl[i]);
      end

      // Flush while waiting for data: drain, no request until data_ok, then reissue
      cur_txn = 100;
      next_cycle();
      set_access(1, 0, 0, 4'b1111, 0, 32'h0000_A000);
      data_addr_ok = 1;
      settle();
      chk("flush_req0", data_req, 1);
      next_cycle();
      data_addr_ok = 0; flush = 1;
      settle();
      chk("flush_wait_req", data_req, 0);
      chk("flush_wait_stall", stall_request_o, 1);
      next_cycle();
      set_access(1, 0, 0, 4'b1111, 0, 32'h0000_B000);
      settle();
      chk("drain_req", data_req, 0);
      chk("drain_stall", stall_request_o, 1);
      next_cycle();
      data_data_ok = 1; data_rdata = 32'h1111_1111;
      settle();
      chk("drain_ok_req", data_req, 0);
      chk("drain_ok_stall", stall_request_o, 1);
      next_cycle();
      data_data_ok = 0; data_addr_ok = 1;
      settle();
      chk("reissue_req", data_req, 1);
      chk("reissue_addr", data_addr, 32'h0000_B000);
      next_cycle();
      data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h2222_2222;
      settle();
      chk("reissue_load", load_data_o, 32'h2222_2222);
      chk("reissue_stall", stall_request_o, 0);
      next_cycle();
      clear_inputs();

      // Asynchronous reset in the middle of a wait
      cur_txn = 101;
      next_cycle();
      set_access(0, 1, 0, 4'b1111, 32'h5555_AAAA, 32'h0000_C000);
      data_addr_ok = 1;
      settle();
      chk("rst_seq_req", data_req, 1);
      next_cycle();
      data_addr_ok = 0;
      settle();
      chk("rst_seq_wait_stall", stall_request_o, 1);
      rst = 1; data_data_ok = 1; data_rdata = 32'hFFFF_FFFF;
      #1;
      chk("midrst_req", data_req, 0);
      chk("midrst_stall", stall_request_o, 0);
      chk("midrst_load", load_data_o, 0);
      chk("midrst_addr", data_addr, 0);
      chk("midrst_wdata", data_wdata, 0);
      chk("midrst_wr", data_wr, 0);
      next_cycle();
      rst = 0;
      clear_inputs();
      settle();
      chk("postrst_stall", stall_request_o, 0);

`ifdef DMEM_UNALIGNED_EXC_EN
      cur_txn = 102;
      next_cycle();
      set_access(1, 0, 0, 4'b1111, 0, 32'h0000_1002);
      settle();
      chk("unal_ld_req", data_req, 0);
      chk("unal_ld_stall", stall_request_o, 0);
      chk("unal_ld_adel", adel_o, 1);
      chk("unal_ld_ades", ades_o, 0);
      chk("unal_ld_bad", bad_vaddr_o, 32'h0000_1002);
      next_cycle();
      set_access(0, 1, 0, 4'b0011, 32'h1234, 32'h0000_1001);
      settle();
      chk("unal_st_req", data_req, 0);
      chk("unal_st_ades", ades_o, 1);
      chk("unal_st_adel", adel_o, 0);
      chk("unal_st_bad", bad_vaddr_o, 32'h0000_1001);
      next_cycle();
      clear_inputs();
`else
      // Low address bits come from the lane enables alone
      cur_txn = 102;
      do_txn('{1, 0, 0, 4'b1111, 32'h0, 32'h0000_1002, 32'h0BAD_F00D, 0, 1, 0,
               2'd2, 32'h0000_1000, 32'h0, 32'h0BAD_F00D});
`endif

      for (int t = 0; t < 150; t++) begin
         vec_t v;
         logic [31:0] base;
         cur_txn = 1000 + t;
         if ($urandom_range(0, 7) == 0) begin
            next_cycle();
            set_access(1, 0, 0, 4'b1111, 0, 32'h0000_0100);
            if ($urandom_range(0, 1) == 1) exception_type_i = $urandom | 32'h1;
            else flush = 1;
            settle();
            chk("blocked_req", data_req, 0);
            chk("blocked_stall", stall_request_o, 0);
            next_cycle();
            clear_inputs();
         end
         v.rd    = $urandom_range(0, 1);
         v.wr    = ~v.rd;
         v.sext  = $urandom_range(0, 1);
         v.sel   = sels[$urandom_range(0, 6)];
         v.wd    = $urandom;
         base    = $urandom & 32'hFFFF_FFFC;
         v.addr  = base | ref_lane(v.sel);
         v.rdata = $urandom;
         v.aok   = $urandom_range(0, 3);
         v.dok   = $urandom_range(1, 3);
         v.hold  = $urandom_range(0, 2);
         v.e_size  = ref_size(v.sel);
         v.e_addr  = v.addr;
         v.e_wdata = ref_wdata(v.sel, v.wd);
         v.e_load  = ref_load(v.sel, v.sext, v.rdata);
         do_txn(v);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
      $finish;
   end

endmodule
